// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 O-QPSK PHY.
// Holds the framer state enum and the reflected CRC-16 byte step.
package zigbee_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PHR,
    PAYLOAD,
    FCS,
    DONE
  } framer_state_t;

  localparam int          PREAMBLE_NIBBLES = 8;
  localparam logic [7:0]  SFD_BYTE         = 8'hA7;
  localparam logic [15:0] CRC16_POLY_REFL  = 16'h8408;
  localparam int          PHY_MAX_LENGTH   = 127;

  // One byte of CRC-16/KERMIT, bits consumed LSB first.
  function automatic logic [15:0] crc16Next(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_kermit.sv
// Byte-wise CRC-16/KERMIT accumulator, shared by TX framing and RX FCS check.
// Ports: inClock, inReset, inClear, inUpdate, inByte -> outCrc.
import zigbee_pkg::*;

module crc16_kermit (
  input  logic        inClock,
  input  logic        inReset,
  input  logic        inClear,
  input  logic        inUpdate,
  input  logic [7:0]  inByte,
  output logic [15:0] outCrc
);

  always_ff @(posedge inClock) begin
    if (inReset || inClear) begin
      outCrc <= 16'h0000;
    end else if (inUpdate) begin
      outCrc <= crc16Next(outCrc, inByte);
    end
  end

endmodule

// File: rtl/ppdu_framer.sv
// Builds 802.15.4 PPDUs (preamble, SFD, PHR, PSDU, FCS) as nibbles to inFIFO.
// Ports: host start/length/status, PSDU byte valid/ready, FIFO data/strobe.
import zigbee_pkg::*;

module ppdu_framer #(
  parameter int APPEND_FCS = 1,
  parameter int MAX_LENGTH = PHY_MAX_LENGTH
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic [6:0] inLength,
  output logic       outBusy,
  output logic       outError,
  output logic       outDone,
  input  logic [7:0] inByte,
  input  logic       inByteValid,
  output logic       outByteReady,
  input  logic       inFull,
  output logic [3:0] outData,
  output logic       outWriteEnable
);

  framer_state_t state;
  logic [6:0]    length;
  logic [6:0]    byteCnt;
  logic [3:0]    nibCnt;
  logic          nibHi;
  logic [7:0]    byteBuf;
  logic          bufFull;
  logic [3:0]    lastData;
  logic [15:0]   crc;
  logic [15:0]   fcsShift;
  logic          pending;
  logic [3:0]    nibble;
  logic          xfer;
  logic          lenBad;

  assign lenBad = (inLength == 7'd0)
               || (int'(inLength) > MAX_LENGTH)
               || ((APPEND_FCS != 0) && (inLength < 7'd3));

  assign outByteReady = (state == PAYLOAD) && !bufFull
                     && (byteCnt != 7'd0);
  assign xfer = outByteReady && inByteValid;

  assign fcsShift = crc >> {nibCnt[1:0], 2'b00};

  // Nibble offered to the FIFO; falls back to the last written one
  // so outData never moves while nothing is being written.
  always_comb begin
    pending = 1'b0;
    nibble  = lastData;
    case (state)
      PREAMBLE: begin
        pending = 1'b1;
        nibble  = 4'h0;
      end
      SFD: begin
        pending = 1'b1;
        nibble  = nibHi ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
      end
      PHR: begin
        pending = 1'b1;
        nibble  = nibHi ? {1'b0, length[6:4]} : length[3:0];
      end
      PAYLOAD: begin
        pending = bufFull;
        if (bufFull) begin
          nibble = nibHi ? byteBuf[7:4] : byteBuf[3:0];
        end
      end
      FCS: begin
        pending = 1'b1;
        nibble  = fcsShift[3:0];
      end
      default: begin
        pending = 1'b0;
      end
    endcase
  end

  assign outWriteEnable = pending && !inFull;
  assign outData        = nibble;

  crc16_kermit crcUnit (
    .inClock  (inClock),
    .inReset  (inReset),
    .inClear  (state == DONE),
    .inUpdate (xfer),
    .inByte   (inByte),
    .outCrc   (crc)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state    <= IDLE;
      outBusy  <= 1'b0;
      outError <= 1'b0;
      outDone  <= 1'b0;
      length   <= 7'd0;
      byteCnt  <= 7'd0;
      nibCnt   <= 4'd0;
      nibHi    <= 1'b0;
      byteBuf  <= 8'h00;
      bufFull  <= 1'b0;
      lastData <= 4'h0;
    end else begin
      outError <= 1'b0;
      outDone  <= 1'b0;
      if (outWriteEnable) begin
        lastData <= nibble;
      end
      case (state)
        IDLE: begin
          if (inStart) begin
            if (lenBad) begin
              outError <= 1'b1;
            end else begin
              length  <= inLength;
              byteCnt <= (APPEND_FCS != 0) ? inLength - 7'd2
                                           : inLength;
              nibCnt  <= 4'd0;
              nibHi   <= 1'b0;
              outBusy <= 1'b1;
              state   <= PREAMBLE;
            end
          end
        end
        PREAMBLE: begin
          if (outWriteEnable) begin
            if (nibCnt == 4'(PREAMBLE_NIBBLES - 1)) begin
              nibCnt <= 4'd0;
              state  <= SFD;
            end else begin
              nibCnt <= nibCnt + 4'd1;
            end
          end
        end
        SFD: begin
          if (outWriteEnable) begin
            nibHi <= !nibHi;
            if (nibHi) state <= PHR;
          end
        end
        PHR: begin
          if (outWriteEnable) begin
            nibHi <= !nibHi;
            if (nibHi) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            byteBuf <= inByte;
            bufFull <= 1'b1;
            byteCnt <= byteCnt - 7'd1;
          end else if (outWriteEnable) begin
            if (nibHi) begin
              nibHi   <= 1'b0;
              bufFull <= 1'b0;
              if (byteCnt == 7'd0) begin
                nibCnt <= 4'd0;
                if (APPEND_FCS != 0) begin
                  state <= FCS;
                end else begin
                  outDone <= 1'b1;
                  state   <= DONE;
                end
              end
            end else begin
              nibHi <= 1'b1;
            end
          end
        end
        FCS: begin
          if (outWriteEnable) begin
            if (nibCnt == 4'd3) begin
              outDone <= 1'b1;
              state   <= DONE;
            end else begin
              nibCnt <= nibCnt + 4'd1;
            end
          end
        end
        DONE: begin
          outBusy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ppdu_framer.md
Name: ppdu_framer

Overview:
- Builds IEEE 802.15.4 O-QPSK PPDUs ahead of the transmit path: preamble, SFD, PHR, PSDU and an optional FCS.
- Emits the frame as 4-bit nibbles with a write strobe into the inFIFO data/write-enable inputs, replacing the test-demux write path.
- Takes the frame length and a start pulse from the host, then pulls PSDU bytes through a valid/ready handshake.
- Computes and appends the 16-bit FCS itself.

Parameters:
- APPEND_FCS, 1: when 1, the block appends a 2-byte FCS; host supplies inLength-2 bytes. When 0, host supplies all inLength bytes.
- MAX_LENGTH, 127: largest legal PHR length value.

Ports:
- inClock  in  1  system clock
- inReset  in  1  synchronous, active-high reset
- inStart  in  1  one-cycle start request; inLength sampled in the same cycle
- inLength  in  7  PSDU length in bytes, FCS included
- outBusy  out  1  frame in progress
- outError  out  1  one-cycle pulse: start rejected for an illegal length
- outDone  out  1  one-cycle pulse: last nibble written
- inByte  in  8  PSDU byte from host
- inByteValid  in  1  inByte valid
- outByteReady  out  1  framer accepts inByte this cycle
- inFull  in  1  inFIFO full flag
- outData  out  4  nibble to inFIFO
- outWriteEnable  out  1  write strobe to inFIFO

Behaviour:
- Clocking and reset: one clock, inClock. Reset is synchronous, active-high, on inReset.
- Reset values: all outputs 0, state IDLE, CRC register 0x0000, byte buffer empty.
- Reset mid-frame: return to IDLE. No write in the cycle after reset. The partial frame is abandoned.
- Write rule: outWriteEnable=1 only in cycles where inFull=0 and a nibble is pending. While stalled, outData holds its value. At most one nibble per cycle.
- Nibble order: each byte goes low nibble first, then high nibble. Bytes go in transmission order.
- IDLE:
  - inStart with a legal length: latch the length, set outBusy, go to PREAMBLE.
  - Illegal length: inLength=0, or inLength>MAX_LENGTH, or (APPEND_FCS=1 and inLength<3). Pulse outError the next cycle and stay IDLE.
  - inStart while outBusy=1 is ignored.
- PREAMBLE: 8 nibbles of 0x0 (4 octets 0x00).
- SFD: byte 0xA7, sent as nibbles 0x7 then 0xA.
- PHR: byte {1'b0, length}, sent low nibble then high nibble.
- PAYLOAD:
  - Byte count N = length-2 if APPEND_FCS=1, else length.
  - outByteReady = 1 when state=PAYLOAD, the byte buffer is empty and bytes remain.
  - A byte transfers when inByteValid && outByteReady. It is loaded into the buffer and the CRC is updated in the same cycle.
  - The byte is then written as two nibbles; the buffer empties after the high-nibble write.
  - Peak rate: one byte per 3 cycles.
  - inByteValid low: no write and no state change.
- FCS (only when APPEND_FCS=1):
  - CRC-16/KERMIT: poly 0x1021 reflected (0x8408), init 0x0000, LSB-first input, no final xor.
  - Sent as 4 nibbles, starting from the least significant nibble: crc[3:0], crc[7:4], crc[11:8], crc[15:12].
- DONE: pulse outDone in the cycle after the last write, clear outBusy and the CRC, return to IDLE.
- Latency and length:
  - inStart at cycle T gives the first write at T+1 if inFull=0.
  - Total writes = 12 + 2*length.
- Counters: nibble counter 4 bits (preamble/FCS); byte counter 7 bits, counting down and ending at zero (no wrap).

Decomposition:
- Package zigbee_pkg holds:
  - framer_state_t enum (IDLE, PREAMBLE, SFD, PHR, PAYLOAD, FCS, DONE)
  - PREAMBLE_NIBBLES=8, SFD_BYTE=8'hA7, CRC16_POLY_REFL=16'h8408, PHY_MAX_LENGTH=127
- Sub-module crc16_kermit: byte-wise combinational next-CRC function around a 16-bit register. It has clear and update inputs, is instanced once, and is reusable by the receive side for FCS checking.

Test Plan:
- Length 3, payload 0x00, inFull=0:
  - Nibbles 0×8, 7, A, 3, 0, 0, 0, 0, 0, 0, 0.
  - 18 writes on consecutive write-eligible cycles; outDone at last write+1.
- Length 11, payload 0x31..0x39 ("123456789"):
  - FCS 0x2189, sent as nibbles 9, 8, 1, 2.
  - 34 writes total; PHR nibbles B, 0.
- Back-pressure: inFull=1 for 5 cycles starting at the PHR high nibble:
  - No writes during the stall; outData held at 0x0.
  - Stream resumes with the same nibble; frame content unchanged.
- Byte starvation: inByteValid=0 for 10 cycles mid-payload:
  - outByteReady stays 1, no writes, outBusy=1.
  - After valid returns, the remaining nibbles are correct and the FCS is unchanged versus the unstalled run.
- Illegal start: inLength=2 with APPEND_FCS=1:
  - outError pulses once, no writes, outBusy=0.
  - A following legal start works.
- Reset in the middle of the payload:
  - No write in the cycle after reset; outBusy=0; CRC cleared.
  - A following length-3 frame gives exactly the stream from the first test.
